// File: rtl/l2recv_pkg.sv
// Shared bus definitions: command codes, agent IDs, slot geometry and the
// small types the L2 receive block passes between its files.
package l2recv_pkg;

    localparam int SLOT_LEN = 8;
    localparam int SLOT_W   = $clog2(SLOT_LEN);

    localparam logic [2:0] CMD_IDLE    = 3'd0;
    localparam logic [2:0] CMD_BUSRD   = 3'd1;
    localparam logic [2:0] CMD_BUSRDX  = 3'd2;
    localparam logic [2:0] CMD_BUSUPGR = 3'd3;
    localparam logic [2:0] CMD_FLUSH   = 3'd4;
    localparam logic [2:0] CMD_WRBACK  = 3'd5;

    localparam logic [1:0] BUSID_CPU0 = 2'd0;
    localparam logic [1:0] BUSID_CPU1 = 2'd1;
    localparam logic [1:0] BUSID_L2   = 2'd2;
    localparam logic [1:0] BUSID_IO   = 2'd3;

    // 34-bit snoop queue payload
    typedef struct packed {
        logic [2:0]  cmd;
        logic [4:0]  tag;
        logic [31:6] addr;
    } snoop_t;

    typedef enum logic {
        FILL_FREE  = 1'b0,
        FILL_DRAIN = 1'b1
    } fill_state_e;

    function automatic logic is_snoop_cmd(input logic [2:0] cmd);
        return (cmd == CMD_BUSRD) || (cmd == CMD_BUSRDX) ||
               (cmd == CMD_BUSUPGR) || (cmd == CMD_FLUSH);
    endfunction

endpackage

// File: rtl/l2recv_snpq.sv
// Two-entry snoop request FIFO between the bus receiver and l2tag.
// Push is ignored when full and pop when empty, so callers may be loose.
module l2recv_snpq
    import l2recv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  snoop_t push_data,
    input  logic   pop,
    output snoop_t head,
    output logic   valid,
    output logic   full
);

    snoop_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/l2recv.sv
// L2 bus receiver: captures own FLUSH fills into a staged line buffer and
// streams them to l2data; queues foreign coherent commands for l2tag.
// Optional build macro L2RECV_STATS_EN adds a saturating nack counter port.
//
// state      | meaning
// FILL_FREE  | line buffer empty, next own fill may commit
// FILL_DRAIN | committed line streaming to l2data, beat drain_idx on output
module l2recv
    import l2recv_pkg::*;
#(
    parameter logic [1:0] BUSID = BUSID_L2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_valid,
    input  logic [2:0]  bus_cmd,
    input  logic [4:0]  bus_tag,
    input  logic [31:6] bus_addr,
    input  logic [63:0] bus_data,
    input  logic        bus_nack,
    output logic        l2recv_bus_nack,
    output logic        l2recv_fill_valid,
    output logic [2:0]  l2recv_fill_tag,
    output logic [31:6] l2recv_fill_addr,
    output logic [63:0] l2recv_fill_data,
    output logic        l2recv_fill_last,
    input  logic        l2data_fill_ready,
    output logic        l2recv_snoop_valid,
    output logic [2:0]  l2recv_snoop_cmd,
    output logic [4:0]  l2recv_snoop_tag,
    output logic [31:6] l2recv_snoop_addr,
    input  logic        l2tag_snoop_ready,
    output logic        l2recv_idle
`ifdef L2RECV_STATS_EN
    ,
    output logic [15:0] l2recv_nack_cnt
`endif
);

    localparam logic [SLOT_W-1:0] LAST_BEAT = SLOT_W'(SLOT_LEN - 1);

    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] drain_idx;
    fill_state_e       fill_state;

    logic [63:0] cap_data [SLOT_LEN-1];
    logic [2:0]  cap_tag;
    logic [31:6] cap_addr;
    logic [63:0] buf_data [SLOT_LEN];

    logic   slot_commit;
    logic   fill_match;
    logic   snoop_match;
    logic   fill_hs;
    logic   fill_busy;
    logic   fill_commit;
    logic   snoop_push;
    logic   snoop_pop;
    logic   snpq_full;
    logic   snpq_valid;
    snoop_t snpq_head;

    assign slot_commit = (slot == LAST_BEAT);
    assign fill_match  = bus_valid && (bus_cmd == CMD_FLUSH) && (bus_tag[4:3] == BUSID);
    assign snoop_match = bus_valid && (bus_tag[4:3] != BUSID) && is_snoop_cmd(bus_cmd);

    // A drain finishing its last beat this cycle frees the buffer in time
    // for a commit in the same cycle.
    assign fill_hs     = l2recv_fill_valid & l2data_fill_ready;
    assign fill_busy   = (fill_state == FILL_DRAIN) & ~(fill_hs & (drain_idx == LAST_BEAT));
    assign fill_commit = slot_commit & fill_match & ~fill_busy & ~bus_nack;

    assign snoop_push  = slot_commit & snoop_match & ~snpq_full & ~bus_nack;
    assign snoop_pop   = snpq_valid & l2tag_snoop_ready;

    assign l2recv_bus_nack  = slot_commit & ((fill_match & fill_busy) | (snoop_match & snpq_full));
    assign l2recv_fill_data = buf_data[drain_idx];
    assign l2recv_fill_last = l2recv_fill_valid & (drain_idx == LAST_BEAT);
    assign l2recv_idle      = (fill_state == FILL_FREE) & ~snpq_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot              <= '0;
            fill_state        <= FILL_FREE;
            drain_idx         <= '0;
            l2recv_fill_valid <= 1'b0;
        end else begin
            slot <= slot + 1'b1;
            case (fill_state)
                FILL_FREE: begin
                    if (fill_commit) begin
                        fill_state        <= FILL_DRAIN;
                        drain_idx         <= '0;
                        l2recv_fill_valid <= 1'b1;
                    end
                end
                FILL_DRAIN: begin
                    if (fill_commit) begin
                        drain_idx         <= '0;
                        l2recv_fill_valid <= 1'b1;
                    end else if (fill_hs) begin
                        drain_idx <= drain_idx + 1'b1;
                        if (drain_idx == LAST_BEAT) begin
                            fill_state        <= FILL_FREE;
                            l2recv_fill_valid <= 1'b0;
                        end
                    end
                end
                default: fill_state <= FILL_FREE;
            endcase
        end
    end

    // Beats stage separately so a line still draining is never overwritten
    // by a capture that ends up nacked.
    always_ff @(posedge clk) begin
        if (fill_match && !slot_commit) cap_data[slot] <= bus_data;
        if (fill_match && slot == '0) begin
            cap_tag  <= bus_tag[2:0];
            cap_addr <= bus_addr;
        end
        if (fill_commit) begin
            for (int i = 0; i < SLOT_LEN - 1; i++) buf_data[i] <= cap_data[i];
            buf_data[LAST_BEAT] <= bus_data;
            l2recv_fill_tag     <= cap_tag;
            l2recv_fill_addr    <= cap_addr;
        end
    end

    l2recv_snpq u_snpq (
        .clk       (clk),
        .rst       (rst),
        .push      (snoop_push),
        .push_data ('{cmd: bus_cmd, tag: bus_tag, addr: bus_addr}),
        .pop       (snoop_pop),
        .head      (snpq_head),
        .valid     (snpq_valid),
        .full      (snpq_full)
    );

    assign l2recv_snoop_valid = snpq_valid;
    assign l2recv_snoop_cmd   = snpq_head.cmd;
    assign l2recv_snoop_tag   = snpq_head.tag;
    assign l2recv_snoop_addr  = snpq_head.addr;

`ifdef L2RECV_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            l2recv_nack_cnt <= '0;
        end else if (l2recv_bus_nack && l2recv_nack_cnt != 16'hFFFF) begin
            l2recv_nack_cnt <= l2recv_nack_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2recv.sv
// Directed bench for l2recv: a table of bus slots with hand-computed
// per-slot expectations, plus reset-in-flight sequences.
module tb_l2recv;
    import l2recv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_valid;
    logic [2:0]  bus_cmd;
    logic [4:0]  bus_tag;
    logic [31:6] bus_addr;
    logic [63:0] bus_data;
    logic        bus_nack;
    logic        l2recv_bus_nack;
    logic        l2recv_fill_valid;
    logic [2:0]  l2recv_fill_tag;
    logic [31:6] l2recv_fill_addr;
    logic [63:0] l2recv_fill_data;
    logic        l2recv_fill_last;
    logic        l2data_fill_ready;
    logic        l2recv_snoop_valid;
    logic [2:0]  l2recv_snoop_cmd;
    logic [4:0]  l2recv_snoop_tag;
    logic [31:6] l2recv_snoop_addr;
    logic        l2tag_snoop_ready;
    logic        l2recv_idle;
`ifdef L2RECV_STATS_EN
    logic [15:0] l2recv_nack_cnt;
`endif

    always #5 clk = ~clk;

    l2recv dut (
        .clk                (clk),
        .rst                (rst),
        .bus_valid          (bus_valid),
        .bus_cmd            (bus_cmd),
        .bus_tag            (bus_tag),
        .bus_addr           (bus_addr),
        .bus_data           (bus_data),
        .bus_nack           (bus_nack),
        .l2recv_bus_nack    (l2recv_bus_nack),
        .l2recv_fill_valid  (l2recv_fill_valid),
        .l2recv_fill_tag    (l2recv_fill_tag),
        .l2recv_fill_addr   (l2recv_fill_addr),
        .l2recv_fill_data   (l2recv_fill_data),
        .l2recv_fill_last   (l2recv_fill_last),
        .l2data_fill_ready  (l2data_fill_ready),
        .l2recv_snoop_valid (l2recv_snoop_valid),
        .l2recv_snoop_cmd   (l2recv_snoop_cmd),
        .l2recv_snoop_tag   (l2recv_snoop_tag),
        .l2recv_snoop_addr  (l2recv_snoop_addr),
        .l2tag_snoop_ready  (l2tag_snoop_ready),
        .l2recv_idle        (l2recv_idle)
`ifdef L2RECV_STATS_EN
        ,
        .l2recv_nack_cnt    (l2recv_nack_cnt)
`endif
    );

    typedef struct {
        logic        valid;
        logic [2:0]  cmd;
        logic [4:0]  tag;
        logic [25:0] addr;
        logic [63:0] dbase;
        logic        bn;
        logic        fr;
        logic        sr;
        logic        sr7;
        logic        exp_nack7;
        int          exp_beats;
        int          exp_pops;
        logic        exp_idle;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [2:0]  tag;
        logic [25:0] addr;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [4:0]  tag;
        logic [25:0] addr;
    } snp_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    beat_t fq[$];
    snp_t  sq[$];
    vec_t  tbl[23];

    localparam logic [1:0] OWN = BUSID_L2;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [2:0] cmd, input logic [4:0] tag,
                                input logic [25:0] addr, input logic [63:0] dbase, input logic bn,
                                input logic fr, input logic sr, input logic sr7, input logic en7,
                                input int beats, input int pops, input logic idle);
        vec_t r;
        r.valid = v; r.cmd = cmd; r.tag = tag; r.addr = addr; r.dbase = dbase; r.bn = bn;
        r.fr = fr; r.sr = sr; r.sr7 = sr7; r.exp_nack7 = en7; r.exp_beats = beats;
        r.exp_pops = pops; r.exp_idle = idle;
        return r;
    endfunction

    task automatic bus_quiet();
        bus_valid = 1'b0; bus_cmd = CMD_IDLE; bus_tag = '0; bus_addr = '0;
        bus_data = '0; bus_nack = 1'b0;
    endtask

    task automatic reset_checks(input string tagname);
        chk({tagname, "_fill_valid"}, 64'(l2recv_fill_valid), 64'd0);
        chk({tagname, "_snoop_valid"}, 64'(l2recv_snoop_valid), 64'd0);
        chk({tagname, "_bus_nack"}, 64'(l2recv_bus_nack), 64'd0);
        chk({tagname, "_idle"}, 64'(l2recv_idle), 64'd1);
    endtask

    // Entered #1 after a posedge with the DUT at slot cycle 0.
    task automatic do_slot(input int idx, input vec_t v);
        logic [7:0] nack_pat;
        int         beats;
        int         pops;
        logic       idle7;
        beats = 0; pops = 0; nack_pat = '0; idle7 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_valid = v.valid; bus_cmd = v.cmd; bus_tag = v.tag; bus_addr = v.addr;
            bus_data = v.dbase + 64'(i);
            bus_nack = 1'b0;
            l2data_fill_ready = v.fr;
            l2tag_snoop_ready = (i == 7) ? v.sr7 : v.sr;
            if (i == 7) begin
                #1;
                bus_nack = v.bn | l2recv_bus_nack;
            end
            @(negedge clk);
            nack_pat[i] = l2recv_bus_nack;
            if (l2recv_fill_valid && l2data_fill_ready) begin
                fq.push_back('{l2recv_fill_data, l2recv_fill_last, l2recv_fill_tag,
                               l2recv_fill_addr, cyc});
                beats++;
            end
            if (l2recv_snoop_valid && l2tag_snoop_ready) begin
                sq.push_back('{l2recv_snoop_cmd, l2recv_snoop_tag, l2recv_snoop_addr});
                pops++;
            end
            if (i == 7) idle7 = l2recv_idle;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("slot%0d_nack_pattern", idx), 64'(nack_pat), 64'({v.exp_nack7, 7'b0}));
        chk($sformatf("slot%0d_fill_beats", idx), 64'(beats), 64'(v.exp_beats));
        chk($sformatf("slot%0d_snoop_pops", idx), 64'(pops), 64'(v.exp_pops));
        chk($sformatf("slot%0d_idle_at7", idx), 64'(idle7), 64'(v.exp_idle));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fbase [4];
        logic [2:0]  ftag  [4];
        logic [25:0] faddr [4];
        snp_t        sexp  [6];
        int          fv_cnt;
        int          nidle_cnt;
        int          beats;

        fbase = '{64'h10, 64'h20, 64'h40, 64'h50};
        ftag  = '{3'd5, 3'd2, 3'd4, 3'd6};
        faddr = '{26'h0ABCDE, 26'h111, 26'h444, 26'h555};
        sexp  = '{'{CMD_BUSRD, 5'b01_000, 26'd1}, '{CMD_BUSRD, 5'b01_000, 26'd2},
                  '{CMD_BUSRD, 5'b01_000, 26'd4}, '{CMD_BUSRD, 5'b01_000, 26'd5},
                  '{CMD_FLUSH, 5'b01_001, 26'd7}, '{CMD_BUSUPGR, 5'b00_010, 26'd8}};

        //           v  cmd          tag           addr        dbase  bn fr sr s7  n7 bt pp idle
        tbl[0]  = mk(1, CMD_FLUSH,   {OWN, 3'd5},  26'h0ABCDE, 64'h10, 0, 1, 1, 1, 0, 0, 0, 1);
        tbl[1]  = mk(0, CMD_IDLE,    5'd0,         26'h0,      64'h0,  0, 1, 1, 1, 0, 8, 0, 0);
        tbl[2]  = mk(1, CMD_FLUSH,   {OWN, 3'd5},  26'h0ABCDE, 64'h10, 1, 1, 1, 1, 0, 0, 0, 1);
        tbl[3]  = mk(0, CMD_IDLE,    5'd0,         26'h0,      64'h0,  0, 1, 1, 1, 0, 0, 0, 1);
        tbl[4]  = mk(1, CMD_BUSRDX,  {OWN, 3'd3},  26'h333,    64'h0,  0, 1, 1, 1, 0, 0, 0, 1);
        tbl[5]  = mk(0, CMD_IDLE,    5'd0,         26'h0,      64'h0,  0, 1, 1, 1, 0, 0, 0, 1);
        tbl[6]  = mk(1, CMD_FLUSH,   {OWN, 3'd2},  26'h111,    64'h20, 0, 0, 1, 1, 0, 0, 0, 1);
        tbl[7]  = mk(1, CMD_FLUSH,   {OWN, 3'd3},  26'h222,    64'h30, 0, 0, 1, 1, 1, 0, 0, 0);
        tbl[8]  = mk(0, CMD_IDLE,    5'd0,         26'h0,      64'h0,  0, 1, 1, 1, 0, 8, 0, 0);
        tbl[9]  = mk(1, CMD_FLUSH,   {OWN, 3'd4},  26'h444,    64'h40, 0, 1, 1, 1, 0, 0, 0, 1);
        tbl[10] = mk(1, CMD_FLUSH,   {OWN, 3'd6},  26'h555,    64'h50, 0, 1, 1, 1, 0, 8, 0, 0);
        tbl[11] = mk(0, CMD_IDLE,    5'd0,         26'h0,      64'h0,  0, 1, 1, 1, 0, 8, 0, 0);
        tbl[12] = mk(1, CMD_BUSRD,   5'b01_000,    26'd1,      64'h0,  0, 1, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(1, CMD_BUSRD,   5'b01_000,    26'd2,      64'h0,  0, 1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, CMD_BUSRD,   5'b01_000,    26'd3,      64'h0,  0, 1, 0, 0, 1, 0, 0, 0);
        tbl[15] = mk(0, CMD_IDLE,    5'd0,         26'h0,      64'h0,  0, 1, 1, 1, 0, 0, 2, 1);
        tbl[16] = mk(1, CMD_BUSRD,   5'b01_000,    26'd4,      64'h0,  0, 1, 0, 0, 0, 0, 0, 1);
        tbl[17] = mk(1, CMD_BUSRD,   5'b01_000,    26'd5,      64'h0,  0, 1, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, CMD_BUSRD,   5'b01_000,    26'd6,      64'h0,  0, 1, 0, 1, 1, 0, 1, 0);
        tbl[19] = mk(0, CMD_IDLE,    5'd0,         26'h0,      64'h0,  0, 1, 1, 1, 0, 0, 1, 1);
        tbl[20] = mk(1, CMD_FLUSH,   5'b01_001,    26'd7,      64'h0,  0, 1, 0, 0, 0, 0, 0, 1);
        tbl[21] = mk(1, CMD_BUSUPGR, 5'b00_010,    26'd8,      64'h0,  0, 1, 0, 1, 0, 0, 1, 0);
        tbl[22] = mk(0, CMD_IDLE,    5'd0,         26'h0,      64'h0,  0, 1, 1, 1, 0, 0, 1, 1);

        rst = 1'b1;
        bus_quiet();
        l2data_fill_ready = 1'b1;
        l2tag_snoop_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        for (int s = 0; s < 23; s++) do_slot(s, tbl[s]);

        chk("fill_total_beats", 64'(fq.size()), 64'd32);
        for (int k = 0; k < fq.size() && k < 32; k++) begin
            chk($sformatf("fill_beat%0d_data", k), fq[k].data, fbase[k / 8] + 64'(k % 8));
            chk($sformatf("fill_beat%0d_meta", k), 64'({fq[k].last, fq[k].tag, fq[k].addr}),
                64'({(k % 8) == 7, ftag[k / 8], faddr[k / 8]}));
            if (k < 8) chk($sformatf("fill_beat%0d_cycle", k), 64'(fq[k].cyc), 64'(8 + k));
        end

        chk("snoop_total_pops", 64'(sq.size()), 64'd6);
        for (int k = 0; k < sq.size() && k < 6; k++)
            chk($sformatf("snoop_pop%0d", k), 64'({sq[k].cmd, sq[k].tag, sq[k].addr}),
                64'({sexp[k].cmd, sexp[k].tag, sexp[k].addr}));

`ifdef L2RECV_STATS_EN
        chk("nack_cnt", 64'(l2recv_nack_cnt), 64'd3);
`endif

        // Reset in the middle of a drain: three beats out, then nothing.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        do_slot(23, mk(1, CMD_FLUSH, {OWN, 3'd1}, 26'h666, 64'h60, 0, 1, 1, 1, 0, 0, 0, 1));
        bus_quiet();
        beats = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (l2recv_fill_valid) beats++;
            @(posedge clk);
            #1;
        end
        chk("middrain_beats_before_rst", 64'(beats), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_checks("middrain_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        fv_cnt = 0;
        nidle_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (l2recv_fill_valid) fv_cnt++;
            if (!l2recv_idle) nidle_cnt++;
            @(posedge clk);
            #1;
        end
        chk("middrain_no_beats_after_rst", 64'(fv_cnt), 64'd0);
        chk("middrain_idle_after_rst", 64'(nidle_cnt), 64'd0);

        // Reset in the middle of a capture: the partial line never appears.
        for (int i = 0; i < 4; i++) begin
            bus_valid = 1'b1; bus_cmd = CMD_FLUSH; bus_tag = {OWN, 3'd7};
            bus_addr = 26'h777; bus_data = 64'h70 + 64'(i);
            if (i == 3) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus_quiet();
        cyc = 0;
        do_slot(24, mk(0, CMD_IDLE, 5'd0, 26'h0, 64'h0, 0, 1, 1, 1, 0, 0, 0, 1));
        do_slot(25, mk(0, CMD_IDLE, 5'd0, 26'h0, 64'h0, 0, 1, 1, 1, 0, 0, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2recv.md
L2RECV -- requirements
Module: l2recv

Interface
REQ-001 Parameter: BUSID, default `BUSID_L2, 2-bit agent ID compared against bus_tag[4:3].
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; one clock; synchronous, active-high.
REQ-004 bus_valid  input  1  current 8-cycle bus slot carries a command; held for all 8 cycles.
REQ-005 bus_cmd / bus_tag / bus_addr  input  3 / 5 / [31:6]  command, {agent,seq} tag, line address; stable across the slot.
REQ-006 bus_data  input  64  data beat i on slot cycle i.
REQ-007 bus_nack  input  1  wired-OR nack from all agents, meaningful at slot cycle 7 only.
REQ-008 l2recv_bus_nack  output  1  this block's nack contribution.
REQ-009 l2recv_fill_valid / l2recv_fill_tag[2:0] / l2recv_fill_addr[31:6] / l2recv_fill_data[63:0] / l2recv_fill_last  output  fill beat stream to l2data.
REQ-010 l2data_fill_ready  input  1  l2data accepts current fill beat.
REQ-011 l2recv_snoop_valid / l2recv_snoop_cmd[2:0] / l2recv_snoop_tag[4:0] / l2recv_snoop_addr[31:6]  output  snoop request to l2tag.
REQ-012 l2tag_snoop_ready  input  1  l2tag pops the snoop head.
REQ-013 l2recv_idle  output  1  fill buffer empty and snoop queue empty.

Function
REQ-014 Internal 3-bit slot counter: 0 after reset, +1 per cycle, wraps 7->0; slot cycle 7 = commit cycle.
REQ-015 Fill match: bus_valid & bus_cmd==`CMD_FLUSH & bus_tag[4:3]==BUSID.
REQ-016 Snoop match: bus_valid & bus_tag[4:3]!=BUSID & bus_cmd in {BUSRD, BUSRDX, BUSUPGR, FLUSH}; own-ID non-FLUSH commands ignored.
REQ-017 Fill capture: on fill match with buffer free, beat at cycle i written to entry i; tag[2:0], addr latched at cycle 0.
REQ-018 Fill commits at cycle 7 iff bus_nack==0 (sampled same cycle); nacked fill discarded, buffer stays free.
REQ-019 Fill buffer occupied at cycle 7 of a fill match -> l2recv_bus_nack=1 that cycle; buffer contents untouched.
REQ-020 Fill drain: starts the cycle after commit; fill_valid=1, beats in order 0..7, index advances on fill_valid & l2data_fill_ready; fill_last=1 on beat 7; buffer free after beat 7 handshake.
REQ-021 A new fill may capture in the slot following commit only if drain finished by that slot's cycle 7; otherwise nack per REQ-019.
REQ-022 Snoop queue: 2-entry FIFO; push at cycle 7 on snoop match with bus_nack==0 and not full; pop on snoop_valid & l2tag_snoop_ready.
REQ-023 Queue full at cycle 7 of snoop match -> l2recv_bus_nack=1; simultaneous pop same cycle does not clear nack (full evaluated pre-pop).
REQ-024 Push and pop same cycle with 1 entry: count stays 1, order preserved.
REQ-025 l2recv_bus_nack is combinational from registered state, 0 on cycles 0-6 and when bus_valid=0.
REQ-026 Outputs snoop_* reflect FIFO head; undefined data when valid=0.

Reset
REQ-027 rst: slot counter 0, fill buffer free, drain index 0, snoop queue empty; fill_valid=0, snoop_valid=0, l2recv_bus_nack=0, l2recv_idle=1; data arrays not reset.
REQ-028 rst mid-capture or mid-drain: in-flight fill dropped, no partial beats emitted afterward.

Configuration
REQ-029 Macro L2RECV_STATS_EN: when defined, adds output l2recv_nack_cnt[15:0], +1 each cycle l2recv_bus_nack=1, saturates at 16'hFFFF, 0 on reset; when undefined, port and counter absent, function otherwise identical.

Structure
REQ-030 `CMD_*, `BUSID_* and slot length (8) come from the shared bus definitions package; no local copies.
REQ-031 Snoop queue is sub-module l2recv_snpq (parameterless 2-entry FIFO, 34-bit payload).

Verification
REQ-032 Fill tag {BUSID,3'd5}, addr 26'h0ABCDE, beats 0..7=64'h10..17, ready=1 -> 8 fill beats cycles 8-15, fill_last on beat 64'h17, fill_tag 5.
REQ-033 Same fill with bus_nack=1 at cycle 7 -> no fill_valid, idle stays 1.
REQ-034 Two back-to-back fills, l2data_fill_ready=0 -> second slot l2recv_bus_nack=1 at cycle 7 only; first buffer data unchanged.
REQ-035 Three foreign BUSRD slots (tag 5'b01_000, addrs 1,2,3), l2tag_snoop_ready=0 -> first two queued, third nacked; then ready=1 pops addr 1 then 2.
REQ-036 Own-ID BUSRDX slot -> no snoop push, no nack.
REQ-037 With L2RECV_STATS_EN, 3 nacked slots -> l2recv_nack_cnt=3; preset near 16'hFFFF saturates.
